// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter for the shared register file write port and CDB
// Per-unit result FIFOs are drained round-robin, one result per cycle.
// The granted entry is registered onto wb_* and cdb_*.

module wb_arbiter #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5,
  parameter int NUM_REQ       = 4,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_has_rd,
  input  logic [NUM_REQ*PHYS_REG_BITS-1:0]   req_pd,
  input  logic [NUM_REQ*32-1:0]              req_data,
  input  logic [NUM_REQ*ROB_IDX_BITS-1:0]    req_rob,
  output logic                               wb_we,
  output logic [PHYS_REG_BITS-1:0]           wb_pd,
  output logic [31:0]                        wb_data,
  output logic                               cdb_valid,
  output logic [PHYS_REG_BITS-1:0]           cdb_pd,
  output logic [ROB_IDX_BITS-1:0]            cdb_rob,
  output logic [$clog2(NUM_REQ)-1:0]         grant_idx
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + PHYS_REG_BITS + 32 + ROB_IDX_BITS;

  // Entry layout: {has_rd, pd, data, rob}
  logic [EW-1:0] r_mem    [NUM_REQ][FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr [NUM_REQ];
  logic [PW-1:0] r_rd_ptr [NUM_REQ];
  logic [CW-1:0] r_cnt    [NUM_REQ];
  logic [GW-1:0] r_rr_ptr;

  logic               w_clear;
  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_pop;
  logic [NUM_REQ-1:0] w_nonempty;
  logic               w_grant;
  logic [GW-1:0]      w_gidx;
  logic [GW:0]        w_idx;
  logic [EW-1:0]      w_entry;

  assign w_clear = rst | flush;

  always_comb begin
    req_ready  = '0;
    w_nonempty = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i]  = (r_cnt[i] < CW'(FIFO_DEPTH)) && !w_clear;
      w_nonempty[i] = (r_cnt[i] != '0);
    end
  end

  assign w_push = req_valid & req_ready;

  // Walk the rotation from the far end so the requester closest to r_rr_ptr wins last.
  always_comb begin
    w_grant = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (w_idx >= (GW+1)'(NUM_REQ))
        w_idx = w_idx - (GW+1)'(NUM_REQ);
      if (w_nonempty[w_idx[GW-1:0]]) begin
        w_grant = 1'b1;
        w_gidx  = w_idx[GW-1:0];
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_pop[i] = w_grant && (w_gidx == GW'(i));
  end

  assign w_entry = r_mem[w_gidx][r_rd_ptr[w_gidx]];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_push[i])
        r_mem[i][r_wr_ptr[i]] <= {req_has_rd[i],
                                  req_pd[i*PHYS_REG_BITS +: PHYS_REG_BITS],
                                  req_data[i*32 +: 32],
                                  req_rob[i*ROB_IDX_BITS +: ROB_IDX_BITS]};
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_push[i])
          r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
        if (w_pop[i])
          r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
      if (w_grant)
        r_rr_ptr <= (w_gidx == GW'(NUM_REQ - 1)) ? '0 : w_gidx + GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear || !w_grant) begin
      cdb_valid <= 1'b0;
      cdb_pd    <= '0;
      cdb_rob   <= '0;
      grant_idx <= '0;
      wb_we     <= 1'b0;
      wb_pd     <= '0;
      wb_data   <= '0;
    end else begin
      cdb_valid <= 1'b1;
      cdb_pd    <= w_entry[EW-2 -: PHYS_REG_BITS];
      cdb_rob   <= w_entry[ROB_IDX_BITS-1:0];
      grant_idx <= w_gidx;
      wb_we     <= w_entry[EW-1];
      wb_pd     <= w_entry[EW-2 -: PHYS_REG_BITS];
      wb_data   <= w_entry[ROB_IDX_BITS+31 -: 32];
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard testbench for wb_arbiter
// Expected broadcasts are queued in grant order and compared as the DUT emits them.

module tb_wb_arbiter;

  localparam int P = 6;
  localparam int R = 5;
  localparam int N = 4;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_has_rd;
  logic [N*P-1:0] req_pd;
  logic [N*32-1:0] req_data;
  logic [N*R-1:0] req_rob;
  logic           wb_we;
  logic [P-1:0]   wb_pd;
  logic [31:0]    wb_data;
  logic           cdb_valid;
  logic [P-1:0]   cdb_pd;
  logic [R-1:0]   cdb_rob;
  logic [1:0]     grant_idx;

  int n_checks = 0;
  int n_pass   = 0;

  logic [52:0] exp_q[$];
  logic [52:0] exp_v;
  logic [52:0] obs;

  assign obs = {cdb_valid, wb_we, wb_pd, wb_data, cdb_pd, cdb_rob, grant_idx};

  always #5 clk = ~clk;

  wb_arbiter #(
    .PHYS_REG_BITS(P),
    .ROB_IDX_BITS (R),
    .NUM_REQ      (N),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_has_rd(req_has_rd),
    .req_pd    (req_pd),
    .req_data  (req_data),
    .req_rob   (req_rob),
    .wb_we     (wb_we),
    .wb_pd     (wb_pd),
    .wb_data   (wb_data),
    .cdb_valid (cdb_valid),
    .cdb_pd    (cdb_pd),
    .cdb_rob   (cdb_rob),
    .grant_idx (grant_idx)
  );

  function automatic logic [52:0] mk(input int u, input logic h, input logic [P-1:0] pd,
                                     input logic [31:0] d, input logic [R-1:0] rob);
    return {1'b1, h, pd, d, pd, rob, 2'(u)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int u, input logic h, input logic [P-1:0] pd,
                         input logic [31:0] d, input logic [R-1:0] rob);
    req_valid[u]       = 1'b1;
    req_has_rd[u]      = h;
    req_pd[u*P +: P]   = pd;
    req_data[u*32 +: 32] = d;
    req_rob[u*R +: R]  = rob;
  endtask

  task automatic clr_all();
    req_valid = '0;
  endtask

  task automatic do_reset();
    clr_all();
    flush = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clr_all();
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs !== 53'd0) $display("FAIL reset_outputs: got %h want 0", obs); else n_pass++;
    n_checks++;
    if (req_ready !== 4'h0) $display("FAIL reset_ready_low: got %b want 0000", req_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'hf) $display("FAIL reset_ready_after: got %b want 1111", req_ready); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 1'b1, 6'd5, 32'hDEADBEEF, 5'd3);
    exp_q.push_back(mk(2, 1'b1, 6'd5, 32'hDEADBEEF, 5'd3));
    tick();
    clr_all();
    n_checks++;
    if (obs !== 53'd0) $display("FAIL single_early: got %h want 0", obs); else n_pass++;
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs !== exp_v) $display("FAIL single_out: got %h want %h", obs, exp_v); else n_pass++;
    tick();
    n_checks++;
    if (obs !== 53'd0) $display("FAIL single_idle: got %h want 0", obs); else n_pass++;
  endtask

  task automatic test_contention();
    do_reset();
    for (int u = 0; u < N; u++) begin
      set_req(u, 1'b1, 6'(u + 8), 32'h1000 + u, 5'(u + 16));
      exp_q.push_back(mk(u, 1'b1, 6'(u + 8), 32'h1000 + u, 5'(u + 16)));
    end
    tick();
    clr_all();
    n_checks++;
    if (obs !== 53'd0) $display("FAIL cont_early: got %h want 0", obs); else n_pass++;
    for (int k = 0; k < N; k++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL cont_grant%0d: got %h want %h", k, obs, exp_v); else n_pass++;
    end
    tick();
    n_checks++;
    if (obs !== 53'd0) $display("FAIL cont_idle: got %h want 0", obs); else n_pass++;
    set_req(3, 1'b1, 6'd33, 32'hCAFE0003, 5'd13);
    set_req(0, 1'b1, 6'd30, 32'hCAFE0000, 5'd10);
    exp_q.push_back(mk(0, 1'b1, 6'd30, 32'hCAFE0000, 5'd10));
    exp_q.push_back(mk(3, 1'b1, 6'd33, 32'hCAFE0003, 5'd13));
    tick();
    clr_all();
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL cont_rrwrap%0d: got %h want %h", k, obs, exp_v); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 1'b1, 6'd10, 32'h100, 5'd1);
    set_req(1, 1'b1, 6'd11, 32'hA1,  5'd2);
    set_req(2, 1'b1, 6'd12, 32'h200, 5'd3);
    set_req(3, 1'b1, 6'd13, 32'h300, 5'd4);
    tick();
    set_req(0, 1'b1, 6'd20, 32'h101, 5'd5);
    set_req(1, 1'b1, 6'd21, 32'hA2,  5'd6);
    set_req(2, 1'b1, 6'd22, 32'h201, 5'd7);
    set_req(3, 1'b1, 6'd23, 32'h301, 5'd8);
    exp_q.push_back(mk(0, 1'b1, 6'd10, 32'h100, 5'd1));
    exp_q.push_back(mk(1, 1'b1, 6'd11, 32'hA1,  5'd2));
    exp_q.push_back(mk(2, 1'b1, 6'd12, 32'h200, 5'd3));
    exp_q.push_back(mk(3, 1'b1, 6'd13, 32'h300, 5'd4));
    exp_q.push_back(mk(0, 1'b1, 6'd20, 32'h101, 5'd5));
    exp_q.push_back(mk(1, 1'b1, 6'd21, 32'hA2,  5'd6));
    exp_q.push_back(mk(2, 1'b1, 6'd22, 32'h201, 5'd7));
    exp_q.push_back(mk(3, 1'b1, 6'd23, 32'h301, 5'd8));
    exp_q.push_back(mk(1, 1'b1, 6'd31, 32'hA3,  5'd9));
    tick();
    clr_all();
    set_req(1, 1'b1, 6'd31, 32'hA3, 5'd9);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs !== exp_v) $display("FAIL bp_grant0: got %h want %h", obs, exp_v); else n_pass++;
    n_checks++;
    if (req_ready[1] !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", req_ready[1]); else n_pass++;
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs !== exp_v) $display("FAIL bp_grant1: got %h want %h", obs, exp_v); else n_pass++;
    n_checks++;
    if (req_ready[1] !== 1'b1) $display("FAIL bp_ready_after_pop: got %b want 1", req_ready[1]); else n_pass++;
    tick();
    clr_all();
    for (int k = 2; k < 9; k++) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL bp_grant%0d: got %h want %h", k, obs, exp_v); else n_pass++;
      tick();
    end
    n_checks++;
    if (obs !== 53'd0) $display("FAIL bp_idle: got %h want 0", obs); else n_pass++;
  endtask

  task automatic test_no_dest();
    do_reset();
    set_req(3, 1'b0, 6'd9, 32'h1234, 5'd7);
    exp_q.push_back(mk(3, 1'b0, 6'd9, 32'h1234, 5'd7));
    tick();
    clr_all();
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs !== exp_v) $display("FAIL nodest_out: got %h want %h", obs, exp_v); else n_pass++;
    n_checks++;
    if ({cdb_valid, wb_we} !== 2'b10) $display("FAIL nodest_we: got %b want 10", {cdb_valid, wb_we}); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int u = 0; u < N; u++)
      set_req(u, 1'b1, 6'(u + 40), 32'hF000 + u, 5'(u));
    tick();
    clr_all();
    set_req(0, 1'b1, 6'd50, 32'hF100, 5'd20);
    set_req(1, 1'b1, 6'd51, 32'hF101, 5'd21);
    tick();
    clr_all();
    exp_v = mk(0, 1'b1, 6'd40, 32'hF000, 5'd0);
    n_checks++;
    if (obs !== exp_v) $display("FAIL flush_pre: got %h want %h", obs, exp_v); else n_pass++;
    flush = 1'b1;
    tick();
    n_checks++;
    if (obs !== 53'd0) $display("FAIL flush_out: got %h want 0", obs); else n_pass++;
    n_checks++;
    if (req_ready !== 4'h0) $display("FAIL flush_ready_low: got %b want 0000", req_ready); else n_pass++;
    flush = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'hf) $display("FAIL flush_ready_after: got %b want 1111", req_ready); else n_pass++;
    set_req(3, 1'b1, 6'd63, 32'hBEEF0003, 5'd31);
    set_req(0, 1'b1, 6'd60, 32'hBEEF0000, 5'd30);
    exp_q.push_back(mk(0, 1'b1, 6'd60, 32'hBEEF0000, 5'd30));
    exp_q.push_back(mk(3, 1'b1, 6'd63, 32'hBEEF0003, 5'd31));
    tick();
    clr_all();
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL flush_new%0d: got %h want %h", k, obs, exp_v); else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (obs !== 53'd0) $display("FAIL flush_stale%0d: got %h want 0", k, obs); else n_pass++;
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int u = 0; u < N; u++)
        set_req(u, 1'b1, 6'(u + r * 4), 32'h7000 + r * 16 + u, 5'(u));
      tick();
    end
    clr_all();
    set_req(0, 1'b1, 6'd62, 32'h7777, 5'd9);
    tick();
    clr_all();
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs !== 53'd0) $display("FAIL rstmid_out: got %h want 0", obs); else n_pass++;
    n_checks++;
    if (req_ready !== 4'h0) $display("FAIL rstmid_ready_low: got %b want 0000", req_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'hf) $display("FAIL rstmid_ready_after: got %b want 1111", req_ready); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (obs !== 53'd0) $display("FAIL rstmid_stale%0d: got %h want 0", k, obs); else n_pass++;
    end
    set_req(1, 1'b1, 6'd17, 32'h5A5A5A5A, 5'd17);
    exp_q.push_back(mk(1, 1'b1, 6'd17, 32'h5A5A5A5A, 5'd17));
    tick();
    clr_all();
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs !== exp_v) $display("FAIL rstmid_resume: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      d = $urandom();
      set_req(2, 1'b1, 6'(40 + i), d, 5'(i));
      exp_q.push_back(mk(2, 1'b1, 6'(40 + i), d, 5'(i)));
      n_checks++;
      if (req_ready[2] !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, req_ready[2]); else n_pass++;
      tick();
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) $display("FAIL b2b_out%0d: got %h want %h", i - 1, obs, exp_v); else n_pass++;
      end
    end
    clr_all();
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs !== exp_v) $display("FAIL b2b_out5: got %h want %h", obs, exp_v); else n_pass++;
    tick();
    n_checks++;
    if (obs !== 53'd0) $display("FAIL b2b_idle: got %h want 0", obs); else n_pass++;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = '0;
    req_has_rd = '0;
    req_pd     = '0;
    req_data   = '0;
    req_rob    = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_no_dest();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sharing the physical register file's single write port and the common data bus (CDB) among NUM_REQ functional units (ALU, MUL, DIV, LSU). Each unit pushes completed results into a private FIFO, and a round-robin arbiter drains one result per cycle. The arbiter drives the register file write (data write plus valid set) and the CDB broadcast to reservation stations and the ROB. The write port never backpressures, so the arbiter issues a grant every cycle any FIFO is non-empty.

## Interface
- PHYS_REG_BITS, 6: physical register index width.
- ROB_IDX_BITS, 5: ROB index width.
- NUM_REQ, 4: number of requesting functional units (2..8).
- FIFO_DEPTH, 2: entries per requester FIFO (power of two, ≥2).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush; discards all buffered and in-flight results.
- req_valid  in  NUM_REQ  per-unit result valid.
- req_ready  out  NUM_REQ  per-unit FIFO can accept.
- req_has_rd  in  NUM_REQ  result writes a destination register.
- req_pd  in  NUM_REQ×PHYS_REG_BITS  destination physical register.
- req_data  in  NUM_REQ×32  result value.
- req_rob  in  NUM_REQ×ROB_IDX_BITS  ROB index of the instruction.
- wb_we  out  1  register file write enable (regf_we).
- wb_pd  out  PHYS_REG_BITS  register file write index (rd_s).
- wb_data  out  32  register file write data (rd_v).
- cdb_valid  out  1  broadcast valid.
- cdb_pd  out  PHYS_REG_BITS  broadcast tag.
- cdb_rob  out  ROB_IDX_BITS  broadcast ROB index.
- grant_idx  out  $clog2(NUM_REQ)  requester of the current broadcast (debug/verification).

## Operation
- Handshake: an entry is accepted on a rising edge where req_valid[i] && req_ready[i] and neither rst nor flush is high. {has_rd, pd, data, rob} is pushed into FIFO i.
- req_ready[i] = (occupancy[i] < FIFO_DEPTH) && !rst && !flush.
  - Ready depends only on the registered occupancy.
  - A full FIFO does not accept in the same cycle it is popped.
- Arbitration is combinational over FIFO non-empty flags.
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first non-empty FIFO is granted and popped.
  - At most one grant per cycle.
- rr_ptr update: after a grant to i, rr_ptr ← (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Output registers load the granted entry on the grant edge:
  - cdb_valid ← 1, cdb_pd ← pd, cdb_rob ← rob, grant_idx ← i.
  - wb_pd ← pd, wb_data ← data.
  - wb_we ← has_rd.
- With no grant, the output registers load cdb_valid=0, wb_we=0, and all payload fields 0.
- Results with has_rd=0 (stores, branches) are still broadcast on the CDB for ROB completion, with wb_we=0.
- Per-FIFO push and pop in the same cycle is legal when the FIFO is non-full. Occupancy is then unchanged, and order is preserved.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy counters are $clog2(FIFO_DEPTH)+1 bits.
- flush (one or more cycles): on each flush edge:
  - All FIFO occupancies and pointers go to 0.
  - rr_ptr goes to 0.
  - All output registers are cleared.
  - No push and no grant occur.
- rst: same effect as flush. Reset can occur mid-operation with data in any FIFO; all data is discarded.
- Ordering: within one requester, results leave in acceptance order. No ordering is guaranteed across requesters.

## Timing
- Reset values: wb_we=0, wb_pd=0, wb_data=0, cdb_valid=0, cdb_pd=0, cdb_rob=0, grant_idx=0, req_ready=0 while rst is high. In the cycle after reset, req_ready is all-ones.
- Latency: an entry accepted at edge k into an empty FIFO, with no contention, is granted at edge k+1. It is visible on wb_*/cdb_* during the cycle after edge k+1 and stays there for exactly one cycle.
- Throughput: one broadcast per cycle aggregate. Each requester is guaranteed at least one grant every NUM_REQ cycles while its FIFO is non-empty.
- A single requester streaming alone sustains one result per cycle with req_ready continuously high.
- wb_* and cdb_* are all registered. There is no combinational path from req_* to outputs.

## Test plan
- Single result: reset, then unit 2 pushes pd=5, data=0xDEADBEEF, rob=3, has_rd=1 at edge 1 → cycle after edge 2: wb_we=1, wb_pd=5, wb_data=0xDEADBEEF, cdb_rob=3, grant_idx=2; all outputs 0 the next cycle.
- Contention: all 4 units push one result at the same edge, with rr_ptr=0 → grants on 4 consecutive cycles in order 0, 1, 2, 3; then rr_ptr=0 and outputs idle.
- Backpressure: unit 1 pushes 3 results on consecutive cycles while units 0, 2 and 3 each hold 2 pending results → req_ready[1] drops once occupancy=2; the third result is accepted only after unit 1's first grant; unit 1's 3 results exit in order; no unit waits more than 4 cycles between grants.
- No-destination result: unit 3 pushes has_rd=0, rob=7 → cdb_valid=1, cdb_rob=7, wb_we=0.
- Flush mid-stream: FIFOs hold 5 total entries, flush is high for 1 cycle → the next cycle has cdb_valid=0 and req_ready=0; afterwards req_ready is all-ones, no stale result is ever broadcast, and a new push to unit 0 is granted first.
- Reset mid-operation: full FIFOs, then rst for 1 cycle → every output matches its reset value, no stale entries appear, and normal operation resumes.
